// File: rtl/asip_mem_pkg.sv
// Shared types for the ASIP load/store responder: FSM state encoding and the
// registered request word.
package asip_mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   localparam int MAX_WAIT   = 15;
   localparam int MAX_ADDR_W = 32;
   localparam int MAX_DATA_W = 64;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   // Sized for the widest supported instance; narrower instances zero-extend on capture.
   typedef struct packed {
      logic                  we;
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] wdata;
      logic [MAX_BE_W-1:0]   be;
   } req_t;

endpackage

// File: rtl/asip_byte_ram.sv
// Synchronous single-port word RAM with per-byte write enables.
// Reads return on the cycle after the enabled edge; writes do not update rdata.
module asip_byte_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/asip_mem_responder.sv
// Memory-side responder for the ASIP load/store port: one request at a time,
// programmable wait states, byte-masked access to internal RAM, held response.
module asip_mem_responder
   import asip_mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WS    = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
   localparam logic [3:0] WAIT_INIT = (WS > 0) ? 4'(WS - 1) : 4'd0;

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid
   // and its payload stay stable until that edge, and ready never waits on valid.
   state_t            state;
   state_t            state_nx;
   req_t              req_q;
   logic [3:0]        wait_cnt;
   logic              accept;
   logic              rsp_fire;
   logic              addr_err;
   logic              ram_en;
   logic [DATA_W-1:0] ram_rdata;
   logic              unused_hi;

   assign accept    = req_valid && req_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign addr_err  = req_q.addr >= MAX_ADDR_W'(DEPTH);
   assign unused_hi = |{req_q.wdata >> DATA_W, req_q.be >> BE_W};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (WS > 0) ? WAIT : ACCESS;
         WAIT:    if (wait_cnt == 4'd0) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    if (rsp_fire) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b1;
      ram_en    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            busy      = 1'b0;
         end
         ACCESS:  ram_en = !addr_err;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  wait_cnt <= 4'd0;
      else if (accept)                          wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != 0)  wait_cnt <= wait_cnt - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
      end else if (accept) begin
         req_q <= '{we:    req_we,
                    addr:  MAX_ADDR_W'(req_addr),
                    wdata: MAX_DATA_W'(req_wdata),
                    be:    MAX_BE_W'(req_be)};
      end
   end

   // RAM read data lands on the edge leaving ACCESS; it is captured into the
   // held response registers on the first RESP edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (rsp_fire) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == RESP && !rsp_valid) begin
         rsp_valid <= 1'b1;
         rsp_err   <= addr_err;
         rsp_rdata <= (req_q.we || addr_err) ? '0 : ram_rdata;
      end
   end

   asip_byte_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (IDX_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (req_q.we),
      .addr  (req_q.addr[IDX_W-1:0]),
      .be    (req_q.be[BE_W-1:0]),
      .wdata (req_q.wdata[DATA_W-1:0]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_asip_mem_responder.sv
// Directed bench for asip_mem_responder: one instance with two wait states
// (ADDR_W=11 so out-of-range addresses are reachable) and one with none.
module tb_asip_mem_responder;

   localparam int WS0 = 2;
   localparam int WS1 = 0;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [10:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy      [2];

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   asip_mem_responder #(.DATA_W(32), .ADDR_W(11), .DEPTH(1024), .WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .busy(busy[0])
   );

   asip_mem_responder #(.DATA_W(32), .ADDR_W(11), .DEPTH(1024), .WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .busy(busy[1])
   );

   function automatic int ws(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; hold = cycles rsp_ready stays low after rsp_valid rises.
   task automatic txn(input int d, input logic we, input logic [10:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold, input string tag);
      int          lat;
      logic        stable;
      logic [31:0] held;
      exp_q.push_back(exp_rdata);
      @(negedge clk);
      check({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wdata;
      req_be[d]    = ~be;
      lat = 0;
      while (!rsp_valid[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(2 + ws(d)));
      check({tag, ".rdata"}, rsp_rdata[d], exp_q.pop_front());
      check({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
      held   = rsp_rdata[d];
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         stable &= rsp_valid[d] && (rsp_rdata[d] === held) && !req_ready[d];
      end
      if (hold > 0) check({tag, ".hold"}, 32'(stable), 32'd1);
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check({tag, ".post_valid"}, 32'(rsp_valid[d]), 32'd0);
      check({tag, ".post_rdata"}, rsp_rdata[d], 32'd0);
      check({tag, ".post_idle"}, 32'({req_ready[d], busy[d]}), 32'b10);
   endtask

   // Start a store, then pulse reset one cycle after accept and expect silence.
   task automatic abort_store(input int d, input logic [10:0] addr,
                              input logic [31:0] wdata, input string tag);
      logic seen;
      @(negedge clk);
      check({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = 4'hF;
      @(negedge clk);
      req_valid[d] = 1'b0;
      check({tag, ".busy_before_rst"}, 32'(busy[d]), 32'd1);
      rst[d] = 1'b1;
      @(negedge clk);
      check({tag, ".ready_in_rst"}, 32'(req_ready[d]), 32'd0);
      rst[d] = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= rsp_valid[d];
      end
      check({tag, ".no_rsp"}, 32'(seen), 32'd0);
      check({tag, ".ready_after"}, 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      logic seen;
      for (int d = 0; d < 2; d++) begin
         rst[d]       = 1'b1;
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_be[d]    = '0;
         rsp_ready[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst.ready0", 32'(req_ready[0]), 32'd0);
      check("rst.ready1", 32'(req_ready[1]), 32'd0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset%0d.ready", d), 32'(req_ready[d]), 32'd1);
         check($sformatf("reset%0d.valid", d), 32'(rsp_valid[d]), 32'd0);
         check($sformatf("reset%0d.busy", d),  32'(busy[d]), 32'd0);
         check($sformatf("reset%0d.rdata", d), rsp_rdata[d], 32'd0);
         check($sformatf("reset%0d.err", d),   32'(rsp_err[d]), 32'd0);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= rsp_valid[0] | rsp_valid[1];
      end
      check("reset.no_spurious", 32'(seen), 32'd0);

      // full-word store/load, then masked store
      txn(0, 1'b1, 11'd5, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0, "st5");
      txn(0, 1'b0, 11'd5, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0, "ld5");
      txn(0, 1'b1, 11'd5, 32'h11223344, 4'h5, 32'h0,        1'b0, 0, "st5_be");
      txn(0, 1'b0, 11'd5, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 0, "ld5_be");
      txn(0, 1'b1, 11'd5, 32'h99999999, 4'h0, 32'h0,        1'b0, 0, "st5_be0");
      txn(0, 1'b0, 11'd5, 32'h0,        4'hF, 32'hDE22BE44, 1'b0, 0, "ld5_be0");

      // address boundaries
      txn(0, 1'b1, 11'd1023, 32'hA5A50F0F, 4'hF, 32'h0,        1'b0, 0, "st1023");
      txn(0, 1'b0, 11'd1023, 32'h0,        4'h0, 32'hA5A50F0F, 1'b0, 0, "ld1023");
      txn(0, 1'b1, 11'd0,    32'hCAFE0000, 4'hF, 32'h0,        1'b0, 0, "st0");
      txn(0, 1'b0, 11'd1024, 32'h0,        4'h0, 32'h0,        1'b1, 0, "ld1024");
      txn(0, 1'b1, 11'd1024, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0, "st1024");
      txn(0, 1'b0, 11'd0,    32'h0,        4'h0, 32'hCAFE0000, 1'b0, 0, "ld0_after_err");
      txn(0, 1'b1, 11'd2047, 32'h12345678, 4'hF, 32'h0,        1'b1, 0, "st2047");
      txn(0, 1'b0, 11'd1023, 32'h0,        4'h0, 32'hA5A50F0F, 1'b0, 0, "ld1023_again");

      // backpressure on the response
      txn(0, 1'b0, 11'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 7, "ld5_hold");

      // reset while a store waits
      txn(0, 1'b1, 11'd9, 32'h11111111, 4'hF, 32'h0, 1'b0, 0, "st9");
      abort_store(0, 11'd9, 32'h22222222, "abort9");
      txn(0, 1'b0, 11'd9, 32'h0, 4'h0, 32'h11111111, 1'b0, 0, "ld9_old");

      // zero wait states
      txn(1, 1'b1, 11'd9, 32'h33333333, 4'hF, 32'h0,        1'b0, 0, "z.st9");
      txn(1, 1'b0, 11'd9, 32'h0,        4'h0, 32'h33333333, 1'b0, 0, "z.ld9");
      abort_store(1, 11'd9, 32'h44444444, "z.abort9");
      txn(1, 1'b0, 11'd9, 32'h0,        4'h0, 32'h33333333, 1'b0, 0, "z.ld9_old");
      txn(1, 1'b1, 11'd9, 32'h0000AB00, 4'h2, 32'h0,        1'b0, 3, "z.st9_be");
      txn(1, 1'b0, 11'd9, 32'h0,        4'h0, 32'h3333AB33, 1'b0, 0, "z.ld9_be");
      txn(1, 1'b0, 11'd1500, 32'h0,     4'h0, 32'h0,        1'b1, 0, "z.ld1500");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
